// File: rtl/gl_cmd_sequencer.sv
// gl_cmd_sequencer: GL command decoder/sequencer between instruction fetch and
// the matrix/vertex datapath. One command per valid/ready handshake; multi-cycle
// commands hold cmd_ready low until their sequence completes.
module gl_cmd_sequencer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int NUM_COLOR  = 4,
  parameter int MV_LAT     = 4,
  parameter int PROJ_LAT   = 4,
  parameter int MMUL_LAT   = 14,
  parameter int LOAD_WORDS = 4,
  parameter int ADDR_STEP  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [7:0]                  cmd_opcode,
  input  logic [22:0]                 cmd_imm,
  input  logic [ADDR_W-1:0]           cmd_addr,
  input  logic [4*DATA_W-1:0]         bram_rdata,
  output logic [ADDR_W-1:0]           bram_addr,
  output logic                        bram_mux_sel,
  output logic [NUM_COLOR*DATA_W-1:0] color_out,
  output logic [DATA_W-1:0]           vp_x,
  output logic [DATA_W-1:0]           vp_y,
  output logic [DATA_W-1:0]           vp_w,
  output logic [DATA_W-1:0]           vp_h,
  output logic                        push_en,
  output logic                        pop_en,
  output logic                        load_en,
  output logic                        load_id_en,
  output logic                        mul_en,
  output logic                        persp_en,
  output logic                        mul_type,
  output logic                        matrix_mode,
  output logic                        err_opcode
);

  localparam logic [7:0] OP_BEGIN      = 8'h01;
  localparam logic [7:0] OP_END        = 8'h02;
  localparam logic [7:0] OP_VERTEX     = 8'h03;
  localparam logic [7:0] OP_COLOR      = 8'h04;
  localparam logic [7:0] OP_MATRIXMODE = 8'h10;
  localparam logic [7:0] OP_MULTMATRIX = 8'h11;
  localparam logic [7:0] OP_LOADID     = 8'h12;
  localparam logic [7:0] OP_LOADMATRIX = 8'h13;
  localparam logic [7:0] OP_PUSH       = 8'h14;
  localparam logic [7:0] OP_POP        = 8'h15;
  localparam logic [7:0] OP_VIEWPORT   = 8'h19;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_VTX_MV   = 3'd1;
  localparam logic [2:0] S_VTX_PROJ = 3'd2;
  localparam logic [2:0] S_MMUL     = 3'd3;
  localparam logic [2:0] S_LOAD     = 3'd4;
  localparam logic [2:0] S_RD_WAIT  = 3'd5;

  localparam logic [15:0] MV_LAST   = 16'(MV_LAT - 1);
  localparam logic [15:0] PROJ_LAST = 16'(PROJ_LAT - 1);
  localparam logic [15:0] PROJ_END  = 16'(PROJ_LAT);
  localparam logic [15:0] MMUL_LAST = 16'(MMUL_LAT - 1);
  localparam logic [15:0] LOAD_LAST = 16'(LOAD_WORDS - 1);

  localparam logic [DATA_W-1:0] VP_W_RST = DATA_W'(32'h43A00000);
  localparam logic [DATA_W-1:0] VP_H_RST = DATA_W'(32'h43700000);

  logic [2:0]                  state_q, state_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic                        rd_vp_q, rd_vp_d;
  logic                        rd_phase_q, rd_phase_d;
  logic                        cur_mode_q, cur_mode_d;
  logic                        matrix_mode_q, matrix_mode_d;
  logic                        mul_type_q, mul_type_d;
  logic                        mux_sel_q, mux_sel_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [NUM_COLOR*DATA_W-1:0] color_q, color_d;
  logic [DATA_W-1:0]           vp_x_q, vp_x_d, vp_y_q, vp_y_d;
  logic [DATA_W-1:0]           vp_w_q, vp_w_d, vp_h_q, vp_h_d;
  logic                        push_q, push_d, pop_q, pop_d;
  logic                        load_q, load_d, load_id_q, load_id_d;
  logic                        mul_q, mul_d, persp_q, persp_d, err_q, err_d;
  logic                        accept;
  logic                        unused_imm;

  // Only bit 0 of the immediate carries meaning (matrix mode select).
  assign unused_imm = ^cmd_imm[22:1];

  assign cmd_ready    = (state_q == S_IDLE);
  assign accept       = cmd_valid && cmd_ready;
  assign bram_addr    = addr_q;
  assign bram_mux_sel = mux_sel_q;
  assign color_out    = color_q;
  assign vp_x         = vp_x_q;
  assign vp_y         = vp_y_q;
  assign vp_w         = vp_w_q;
  assign vp_h         = vp_h_q;
  assign push_en      = push_q;
  assign pop_en       = pop_q;
  assign load_en      = load_q;
  assign load_id_en   = load_id_q;
  assign mul_en       = mul_q;
  assign persp_en     = persp_q;
  assign mul_type     = mul_type_q;
  assign matrix_mode  = matrix_mode_q;
  assign err_opcode   = err_q;

  // Next-state decode: command dispatch from IDLE and per-state sequencing.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_vp_d       = rd_vp_q;
    rd_phase_d    = rd_phase_q;
    cur_mode_d    = cur_mode_q;
    matrix_mode_d = matrix_mode_q;
    mul_type_d    = mul_type_q;
    mux_sel_d     = mux_sel_q;
    addr_d        = addr_q;
    color_d       = color_q;
    vp_x_d        = vp_x_q;
    vp_y_d        = vp_y_q;
    vp_w_d        = vp_w_q;
    vp_h_d        = vp_h_q;
    push_d        = 1'b0;
    pop_d         = 1'b0;
    load_d        = 1'b0;
    load_id_d     = 1'b0;
    mul_d         = 1'b0;
    persp_d       = 1'b0;
    err_d         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_opcode)
            OP_BEGIN, OP_END: begin
            end
            OP_MATRIXMODE: cur_mode_d = cmd_imm[0];
            OP_LOADID: begin
              matrix_mode_d = cur_mode_q;
              load_id_d     = 1'b1;
            end
            OP_PUSH: begin
              matrix_mode_d = cur_mode_q;
              push_d        = 1'b1;
            end
            OP_POP: begin
              matrix_mode_d = cur_mode_q;
              pop_d         = 1'b1;
            end
            OP_VERTEX: begin
              mux_sel_d     = 1'b0;
              addr_d        = cmd_addr;
              mul_type_d    = 1'b0;
              matrix_mode_d = 1'b0;
              mul_d         = 1'b1;
              cnt_d         = '0;
              state_d       = S_VTX_MV;
            end
            OP_MULTMATRIX: begin
              mux_sel_d     = 1'b1;
              addr_d        = cmd_addr;
              mul_type_d    = 1'b1;
              matrix_mode_d = cur_mode_q;
              mul_d         = 1'b1;
              cnt_d         = '0;
              state_d       = S_MMUL;
            end
            OP_LOADMATRIX: begin
              mux_sel_d     = 1'b0;
              addr_d        = cmd_addr;
              matrix_mode_d = cur_mode_q;
              load_d        = 1'b1;
              cnt_d         = '0;
              state_d       = S_LOAD;
            end
            OP_COLOR, OP_VIEWPORT: begin
              mux_sel_d  = 1'b0;
              addr_d     = cmd_addr;
              rd_vp_d    = (cmd_opcode == OP_VIEWPORT);
              rd_phase_d = 1'b0;
              state_d    = S_RD_WAIT;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_VTX_MV: begin
        if (cnt_q == MV_LAST) begin
          matrix_mode_d = 1'b1;
          mul_d         = 1'b1;
          cnt_d         = '0;
          state_d       = S_VTX_PROJ;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_VTX_PROJ: begin
        // persp_en is issued from the last counted cycle; the pulse cycle itself
        // is still busy so the next command is taken only after it.
        if (cnt_q == PROJ_LAST) begin
          persp_d = 1'b1;
        end
        if (cnt_q == PROJ_END) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_MMUL: begin
        if (cnt_q == MMUL_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = S_IDLE;
        end else begin
          addr_d = addr_q + ADDR_W'(ADDR_STEP);
          cnt_d  = cnt_q + 16'd1;
        end
      end
      S_RD_WAIT: begin
        // First cycle presents the address; read data is on the lanes in the second.
        if (!rd_phase_q) begin
          rd_phase_d = 1'b1;
        end else begin
          if (rd_vp_q) begin
            vp_x_d = bram_rdata[0*DATA_W +: DATA_W];
            vp_y_d = bram_rdata[1*DATA_W +: DATA_W];
            vp_w_d = bram_rdata[2*DATA_W +: DATA_W];
            vp_h_d = bram_rdata[3*DATA_W +: DATA_W];
          end else begin
            for (int i = 0; i < NUM_COLOR; i++) begin
              color_d[i*DATA_W +: DATA_W] = bram_rdata[i*DATA_W +: DATA_W];
            end
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rd_vp_q       <= 1'b0;
      rd_phase_q    <= 1'b0;
      cur_mode_q    <= 1'b0;
      matrix_mode_q <= 1'b0;
      mul_type_q    <= 1'b0;
      mux_sel_q     <= 1'b0;
      addr_q        <= '0;
      color_q       <= '0;
      vp_x_q        <= '0;
      vp_y_q        <= '0;
      vp_w_q        <= VP_W_RST;
      vp_h_q        <= VP_H_RST;
      push_q        <= 1'b0;
      pop_q         <= 1'b0;
      load_q        <= 1'b0;
      load_id_q     <= 1'b0;
      mul_q         <= 1'b0;
      persp_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_vp_q       <= rd_vp_d;
      rd_phase_q    <= rd_phase_d;
      cur_mode_q    <= cur_mode_d;
      matrix_mode_q <= matrix_mode_d;
      mul_type_q    <= mul_type_d;
      mux_sel_q     <= mux_sel_d;
      addr_q        <= addr_d;
      color_q       <= color_d;
      vp_x_q        <= vp_x_d;
      vp_y_q        <= vp_y_d;
      vp_w_q        <= vp_w_d;
      vp_h_q        <= vp_h_d;
      push_q        <= push_d;
      pop_q         <= pop_d;
      load_q        <= load_d;
      load_id_q     <= load_id_d;
      mul_q         <= mul_d;
      persp_q       <= persp_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_gl_cmd_sequencer.sv
// Testbench for gl_cmd_sequencer: directed and random command streams; a
// command-level model queues expected timed events, a monitor checks them.
module tb_gl_cmd_sequencer;

  localparam int DATA_W = 32, ADDR_W = 32, NUM_COLOR = 4;
  localparam int MV_LAT = 4, PROJ_LAT = 4, MMUL_LAT = 14, LOAD_WORDS = 4, ADDR_STEP = 4;

  localparam int K_MUL = 0, K_PERSP = 1, K_LOAD = 2, K_LOADID = 3, K_PUSH = 4;
  localparam int K_POP = 5, K_ERR = 6, K_ADDR = 7, K_COLOR = 8, K_VP = 9;

  typedef struct {
    int           cyc;
    int           kind;
    logic [127:0] val;
  } ev_t;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [7:0]                  cmd_opcode;
  logic [22:0]                 cmd_imm;
  logic [ADDR_W-1:0]           cmd_addr;
  logic [4*DATA_W-1:0]         bram_rdata;
  logic [ADDR_W-1:0]           bram_addr;
  logic                        bram_mux_sel;
  logic [NUM_COLOR*DATA_W-1:0] color_out;
  logic [DATA_W-1:0]           vp_x, vp_y, vp_w, vp_h;
  logic push_en, pop_en, load_en, load_id_en, mul_en, persp_en, mul_type, matrix_mode, err_opcode;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_until = 0;
  int   last_acc = 0;
  logic cur_mode = 1'b0;
  ev_t  q[$];

  gl_cmd_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_COLOR(NUM_COLOR), .MV_LAT(MV_LAT),
    .PROJ_LAT(PROJ_LAT), .MMUL_LAT(MMUL_LAT), .LOAD_WORDS(LOAD_WORDS), .ADDR_STEP(ADDR_STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_imm(cmd_imm), .cmd_addr(cmd_addr),
    .bram_rdata(bram_rdata), .bram_addr(bram_addr), .bram_mux_sel(bram_mux_sel),
    .color_out(color_out), .vp_x(vp_x), .vp_y(vp_y), .vp_w(vp_w), .vp_h(vp_h),
    .push_en(push_en), .pop_en(pop_en), .load_en(load_en), .load_id_en(load_id_en),
    .mul_en(mul_en), .persp_en(persp_en), .mul_type(mul_type), .matrix_mode(matrix_mode),
    .err_opcode(err_opcode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM contents as a fixed function of address; lanes packed {l3,l2,l1,l0}.
  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [31:0] l [4];
    if (a == 32'h20) begin
      l[0] = 32'h3F800000; l[1] = 32'h0; l[2] = 32'h3F000000; l[3] = 32'h3F800000;
    end else begin
      for (int i = 0; i < 4; i++) l[i] = (a * 32'h9E3779B1) + (32'(i) * 32'h01000193) ^ 32'h5A5A0000;
    end
    return {l[3], l[2], l[1], l[0]};
  endfunction

  always @(posedge clk) bram_rdata <= mem_line(bram_addr);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] mulv(input logic mt, input logic mm, input logic sel, input logic [31:0] a);
    return {93'b0, mt, mm, sel, a};
  endfunction

  task automatic push_ev(input int c, input int k, input logic [127:0] v);
    ev_t e;
    e.cyc = c; e.kind = k; e.val = v;
    q.push_back(e);
  endtask

  // Command-level reference: what each accepted command must produce and when.
  task automatic model_accept(input logic [7:0] op, input logic [22:0] imm, input logic [31:0] a, input int acc);
    logic [127:0] ln;
    ln = mem_line(a);
    last_acc = acc;
    busy_until = acc;
    case (op)
      8'h01, 8'h02: ;
      8'h10: cur_mode = imm[0];
      8'h12: push_ev(acc, K_LOADID, {127'b0, cur_mode});
      8'h14: push_ev(acc, K_PUSH, {127'b0, cur_mode});
      8'h15: push_ev(acc, K_POP, {127'b0, cur_mode});
      8'h03: begin
        push_ev(acc, K_MUL, mulv(1'b0, 1'b0, 1'b0, a));
        push_ev(acc + MV_LAT, K_MUL, mulv(1'b0, 1'b1, 1'b0, a));
        push_ev(acc + MV_LAT + PROJ_LAT, K_PERSP, '0);
        busy_until = acc + MV_LAT + PROJ_LAT + 1;
      end
      8'h11: begin
        push_ev(acc, K_MUL, mulv(1'b1, cur_mode, 1'b1, a));
        busy_until = acc + MMUL_LAT;
      end
      8'h13: begin
        push_ev(acc, K_LOAD, {94'b0, cur_mode, 1'b0, a});
        for (int i = 1; i < LOAD_WORDS; i++) push_ev(acc + i, K_ADDR, {95'b0, 1'b0, a + 32'(i * ADDR_STEP)});
        busy_until = acc + LOAD_WORDS;
      end
      8'h04: begin
        push_ev(acc, K_ADDR, {95'b0, 1'b0, a});
        push_ev(acc + 2, K_COLOR, ln);
        busy_until = acc + 2;
      end
      8'h19: begin
        push_ev(acc, K_ADDR, {95'b0, 1'b0, a});
        push_ev(acc + 2, K_VP, {ln[31:0], ln[63:32], ln[95:64], ln[127:96]});
        busy_until = acc + 2;
      end
      default: push_ev(acc, K_ERR, '0);
    endcase
  endtask

  // Monitor: pop events due this cycle and compare against what the DUT shows.
  always @(negedge clk) begin
    ev_t        e;
    logic [6:0] exp_mask;
    logic [6:0] obs_mask;
    logic       exp_rdy;
    exp_mask = '0;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        chk("stale_event", 128'(cyc), 128'(e.cyc));
      end else begin
        case (e.kind)
          K_MUL: begin
            exp_mask[0] = 1'b1;
            chk("mul_ctrl", mulv(mul_type, matrix_mode, bram_mux_sel, bram_addr), e.val);
          end
          K_PERSP: exp_mask[1] = 1'b1;
          K_LOAD: begin
            exp_mask[2] = 1'b1;
            chk("load_ctrl", {94'b0, matrix_mode, bram_mux_sel, bram_addr}, e.val);
          end
          K_LOADID: begin exp_mask[3] = 1'b1; chk("loadid_mode", {127'b0, matrix_mode}, e.val); end
          K_PUSH: begin exp_mask[4] = 1'b1; chk("push_mode", {127'b0, matrix_mode}, e.val); end
          K_POP: begin exp_mask[5] = 1'b1; chk("pop_mode", {127'b0, matrix_mode}, e.val); end
          K_ERR: exp_mask[6] = 1'b1;
          K_ADDR: chk("bram_addr", {95'b0, bram_mux_sel, bram_addr}, e.val);
          K_COLOR: chk("color_out", color_out, e.val);
          K_VP: chk("viewport", {vp_x, vp_y, vp_w, vp_h}, e.val);
          default: chk("event_kind", 128'(e.kind), 128'(0));
        endcase
      end
    end
    obs_mask = {err_opcode, pop_en, push_en, load_id_en, load_en, persp_en, mul_en};
    chk("pulses", {121'b0, obs_mask}, {121'b0, exp_mask});
    exp_rdy = !(cyc >= last_acc && cyc < busy_until);
    chk("cmd_ready", {127'b0, cmd_ready}, {127'b0, exp_rdy});
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Present a command and hold it until accepted; model is told at accept time.
  task automatic send(input logic [7:0] op, input logic [22:0] imm, input logic [31:0] a);
    int n;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_imm = imm; cmd_addr = a;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 128'(n), 128'(0));
    end else begin
      model_accept(op, imm, a, cyc + 1);
    end
    tick();
  endtask

  task automatic idle;
    cmd_valid  = 1'b0;
    cmd_opcode = 8'($urandom);
    cmd_imm    = 23'($urandom);
    cmd_addr   = $urandom;
  endtask

  function automatic bit is_def(input logic [7:0] op);
    return op inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h19};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] defs [11];
    logic [7:0] op;
    logic [31:0] a;
    int n;
    defs = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h19};
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_imm = '0; cmd_addr = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("rst_vp_w", 128'(vp_w), 128'(32'h43A00000));
    chk("rst_vp_h", 128'(vp_h), 128'(32'h43700000));
    chk("rst_vp_xy", 128'({vp_x, vp_y}), 128'(0));
    chk("rst_color", 128'(color_out), 128'(0));
    chk("rst_ready", 128'(cmd_ready), 128'(1));
    chk("rst_ctrl", {93'b0, matrix_mode, mul_type, bram_mux_sel, bram_addr}, 128'(0));

    // Directed: VERTEX, MATRIXMODE+LOADMATRIX, COLOR, back-to-back PUSH/POP/undefined.
    send(8'h03, 23'h0, 32'h40); idle(); repeat (12) tick();
    send(8'h10, 23'h1, 32'h0);
    send(8'h13, 23'h0, 32'h100); idle(); repeat (6) tick();
    send(8'h04, 23'h0, 32'h20); idle(); repeat (4) tick();
    send(8'h14, 23'h0, 32'h0);
    send(8'h15, 23'h0, 32'h0);
    send(8'hFF, 23'h0, 32'h0); idle(); repeat (3) tick();
    send(8'h19, 23'h0, 32'h300); idle(); repeat (4) tick();

    // Reset in the middle of MULTMATRIX.
    send(8'h11, 23'h0, 32'h200); idle(); repeat (5) tick();
    rst_n = 1'b0;
    q.delete();
    busy_until = 0; last_acc = 0; cur_mode = 1'b0;
    #1;
    chk("abort_ready", 128'(cmd_ready), 128'(1));
    chk("abort_ctrl", {94'b0, matrix_mode, bram_mux_sel, bram_addr}, 128'(0));
    chk("abort_vp", 128'({vp_w, vp_h}), 128'({32'h43A00000, 32'h43700000}));
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();

    // Random command stream.
    for (int k = 0; k < 300; k++) begin
      n = $urandom_range(0, 11);
      if (n == 11) begin
        op = 8'($urandom);
        while (is_def(op)) op = 8'($urandom);
      end else begin
        op = defs[n];
      end
      if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFF0 + 32'($urandom_range(0, 3) * 4);
      else a = $urandom;
      send(op, 23'($urandom), a);
      if ($urandom_range(0, 2) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    idle();
    n = 0;
    while ((cyc < busy_until + 3 || q.size() > 0) && n < 100) begin
      tick();
      n++;
    end
    chk("queue_drained", 128'(q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
